// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU with iterative MULTU/DIVU and HI/LO
`timescale 1ns/1ps
// Execute-stage ALU: single-cycle logic/arith ops, shift-add multiply and
// restoring divide over WIDTH cycles, valid/ready handshake, registered result.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_control,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zf,
  output logic             o_dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;    // multiplicand or divisor
  logic [WIDTH-1:0] r_acc;  // running high half / partial remainder
  logic [WIDTH-1:0] r_q;    // multiplier shifting into LO / dividend shifting into quotient
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_accept, w_is_mul, w_is_div, w_div0, w_last;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_it_acc, w_it_q;

  // Ready is suppressed while reset is held so every output reads 0 under reset
  assign o_ready  = i_rst_n & (r_state == S_IDLE);
  assign w_accept = i_valid & o_ready;
  assign w_is_mul = (i_control == 4'b1000);
  assign w_is_div = (i_control == 4'b1001);
  assign w_div0   = w_is_div & (i_op2 == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: start iterating on accepted MULTU / non-zero DIVU, stop after WIDTH steps
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)                 w_next = S_MUL;
        else if (w_accept && w_is_div && !w_div0) w_next = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle operation results; unknown codes yield 0
  always_comb begin
    w_alu = '0;
    case (i_control)
      4'b0000: w_alu = i_op1 & i_op2;
      4'b0001: w_alu = i_op1 | i_op2;
      4'b0010: w_alu = i_op1 + i_op2;
      4'b0110: w_alu = i_op1 - i_op2;
      4'b1100: w_alu = ~(i_op1 | i_op2);
      4'b0111: w_alu = {{(WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      4'b0011: w_alu = {{(WIDTH-1){1'b0}}, (i_op1 < i_op2)};
      4'b1010: w_alu = r_hi;
      4'b1011: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide
  always_comb begin
    w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_acc, r_q[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_a};
    w_div_ok    = ~w_div_diff[WIDTH];
    if (r_state == S_DIV) begin
      w_it_acc = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_it_q   = {r_q[WIDTH-2:0], w_div_ok};
    end else begin
      w_it_acc = w_mul_sum[WIDTH:1];
      w_it_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end
  end

  // Datapath: operand capture, iteration, HI/LO and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zf     <= 1'b0;
      o_dz     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          if (w_is_mul || (w_is_div && !w_div0)) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_a   <= w_is_mul ? i_op1 : i_op2;
            r_q   <= w_is_mul ? i_op2 : i_op1;
          end else if (w_div0) begin
            r_lo     <= '1;
            r_hi     <= i_op1;
            o_result <= '1;
            o_zf     <= 1'b0;
            o_dz     <= 1'b1;
            o_valid  <= 1'b1;
          end else begin
            o_result <= w_alu;
            o_zf     <= (w_alu == '0);
            o_dz     <= 1'b0;
            o_valid  <= 1'b1;
          end
        end
      end else begin
        r_acc <= w_it_acc;
        r_q   <= w_it_q;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_hi     <= w_it_acc;
          r_lo     <= w_it_q;
          o_result <= w_it_q;
          o_zf     <= (w_it_q == '0);
          o_dz     <= 1'b0;
          o_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
`timescale 1ns/1ps
// Table-driven single-cycle vectors plus hand-written multi-cycle sequences.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [3:0]  ctrl;
  logic [31:0] op1, op2;
  logic        o_valid;
  logic [31:0] result;
  logic        zf, dz;

  int n_checks = 0;
  int n_errors = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_control(ctrl), .i_op1(op1), .i_op2(op2),
    .o_valid(o_valid), .o_result(result), .o_zf(zf), .o_dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_NOR = 4'b1100, C_SLT = 4'b0111,
                         C_SLTU = 4'b0011, C_MFHI = 4'b1010, C_MFLO = 4'b1011,
                         C_MULTU = 4'b1000, C_DIVU = 4'b1001;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one single-cycle op; results expected after the next edge
  task automatic single(input string name, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_dz);
    ctrl = c; op1 = a; op2 = b; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk({name, " valid"}, {31'd0, o_valid}, 32'd1);
    chk({name, " result"}, result, exp);
    chk({name, " zf"}, {31'd0, zf}, {31'd0, (exp == 32'd0)});
    chk({name, " dz"}, {31'd0, dz}, {31'd0, exp_dz});
    chk({name, " ready"}, {31'd0, ready}, 32'd1);
  endtask

  // Issue MULTU/DIVU, optionally keep requesting ADD while busy, expect 32 busy cycles
  task automatic long_op(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit hold_add);
    int busy;
    ctrl = c; op1 = a; op2 = b; valid = 1'b1;
    @(negedge clk);
    if (hold_add) begin
      ctrl = C_ADD; op1 = 32'd1; op2 = 32'd1;
    end else begin
      valid = 1'b0; op1 = $urandom; op2 = $urandom;
    end
    busy = 0;
    while (!o_valid && busy < 100) begin
      if (!ready) busy++;
      @(negedge clk);
    end
    valid = 1'b0;
    chk({name, " busy cycles"}, busy, 32);
    chk({name, " result"}, result, exp);
    chk({name, " zf"}, {31'd0, zf}, {31'd0, (exp == 32'd0)});
    chk({name, " dz"}, {31'd0, dz}, 32'd0);
    chk({name, " ready at done"}, {31'd0, ready}, 32'd1);
    @(negedge clk);
    chk({name, " single pulse"}, {31'd0, o_valid}, 32'd0);
  endtask

  logic [31:0] ma[3] = '{32'h12345678, 32'hFFFFFFFF, 32'h0000FFFF};
  logic [31:0] mb[3] = '{32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00010001};
  logic [31:0] da[3] = '{32'hDEADBEEF, 32'd5,        32'hFFFFFFFF};
  logic [31:0] db[3] = '{32'h00001234, 32'd9,        32'd1};

  initial begin
    logic [63:0] prod;

    vecs[0]  = '{C_ADD,  32'd7,        32'd5,        32'd12,       1'b0};
    vecs[1]  = '{C_SUB,  32'd9,        32'd9,        32'd0,        1'b1};
    vecs[2]  = '{C_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[3]  = '{C_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[4]  = '{4'b0101,32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[5]  = '{C_AND,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0};
    vecs[6]  = '{C_OR,   32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 1'b0};
    vecs[7]  = '{C_NOR,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h000F000F, 1'b0};
    vecs[8]  = '{C_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};
    vecs[9]  = '{C_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[10] = '{C_MFHI, 32'd0,        32'd0,        32'd0,        1'b1};
    vecs[11] = '{C_SLT,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};

    rst_n = 1'b1; valid = 1'b0; ctrl = '0; op1 = '0; op2 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset valid", {31'd0, o_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zf", {31'd0, zf}, 32'd0);
    chk("reset dz", {31'd0, dz}, 32'd0);
    rst_n = 1'b1;
    #1 chk("ready after reset", {31'd0, ready}, 32'd1);

    // Back-to-back single-cycle table
    for (int i = 0; i < 12; i++) begin
      ctrl = vecs[i].c; op1 = vecs[i].a; op2 = vecs[i].b; valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), {31'd0, o_valid}, 32'd1);
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d zf", i), {31'd0, zf}, {31'd0, vecs[i].zf});
      chk($sformatf("vec%0d dz", i), {31'd0, dz}, 32'd0);
    end
    valid = 1'b0;
    @(negedge clk);
    chk("idle no valid", {31'd0, o_valid}, 32'd0);

    long_op("mul ffffffff*2", C_MULTU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0);
    single("mfhi after mul", C_MFHI, 32'd0, 32'd0, 32'd1, 1'b0);
    single("mflo after mul", C_MFLO, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0);

    long_op("div 100/7 held", C_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    single("mfhi after div", C_MFHI, 32'd0, 32'd0, 32'd2, 1'b0);

    for (int i = 0; i < 3; i++) begin
      prod = {32'd0, ma[i]} * {32'd0, mb[i]};
      long_op($sformatf("mul%0d", i), C_MULTU, ma[i], mb[i], prod[31:0], 1'b0);
      single($sformatf("mul%0d hi", i), C_MFHI, 32'd0, 32'd0, prod[63:32], 1'b0);
      long_op($sformatf("div%0d", i), C_DIVU, da[i], db[i], da[i] / db[i], 1'b0);
      single($sformatf("div%0d hi", i), C_MFHI, 32'd0, 32'd0, da[i] % db[i], 1'b0);
      single($sformatf("div%0d lo", i), C_MFLO, 32'd0, 32'd0, da[i] / db[i], 1'b0);
    end

    single("div by zero", C_DIVU, 32'd55, 32'd0, 32'hFFFFFFFF, 1'b1);
    single("mfhi after dz", C_MFHI, 32'd0, 32'd0, 32'd55, 1'b0);
    single("mflo after dz", C_MFLO, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0);

    // Reset during a multiply
    ctrl = C_MULTU; op1 = 32'h1234; op2 = 32'h5678; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset valid", {31'd0, o_valid}, 32'd0);
    chk("midreset result", result, 32'd0);
    chk("midreset zf", {31'd0, zf}, 32'd0);
    chk("midreset dz", {31'd0, dz}, 32'd0);
    chk("midreset ready", {31'd0, ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("in reset no valid", {31'd0, o_valid}, 32'd0);
    end
    rst_n = 1'b1;
    #1 chk("ready after midreset", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      chk("aborted mul no valid", {31'd0, o_valid}, 32'd0);
    end
    single("mflo after reset", C_MFLO, 32'd0, 32'd0, 32'd0, 1'b0);
    single("mfhi after reset", C_MFHI, 32'd0, 32'd0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
